// File: rtl/dff_err_serializer_pkg.sv
// Shared types and constants for the DFF error-count serializer.
//   state_t       : serializer FSM states
//   CRC8_POLY     : CRC-8 generator polynomial (x^8+x^2+x+1)
//   DEF_SYNC_WORD : default frame sync header
//   frame_len()   : total frame length in data_clk cycles
package dff_err_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      HDR  = 2'd1,
      DATA = 2'd2,
      CRC  = 2'd3
   } state_t;

   localparam logic [7:0] CRC8_POLY     = 8'h07;
   localparam logic [7:0] DEF_SYNC_WORD = 8'hA5;

   function automatic int frame_len(input int hdr_w, input int num_ch,
                                    input int cnt_w, input bit crc_en);
      return hdr_w + num_ch * cnt_w + (crc_en ? 8 : 0);
   endfunction

endpackage

// File: rtl/dff_err_serializer_if.sv
// Host-side bundle of the DFF error-count serializer.
//   save_data    : snapshot request (rising edge significant)
//   err_cnt      : flattened error counters, channel k at [k*CNT_W +: CNT_W]
//   chan_en      : per-channel enable, disabled channels send zeros
//   msb_first    : payload bit order
//   DATA_OUT     : serial data
//   frame_active : DATA_OUT carries a frame bit
//   frame_start  : pulse on the first header bit
//   frame_done   : pulse the cycle after the last frame bit
//   overrun      : sticky, a request was lost
// master = counter/host side, slave = serializer.
interface dff_err_serializer_if #(
   parameter int NUM_CH = 20,
   parameter int CNT_W  = 16
);
   logic                     save_data;
   logic [NUM_CH*CNT_W-1:0]  err_cnt;
   logic [NUM_CH-1:0]        chan_en;
   logic                     msb_first;
   logic                     DATA_OUT;
   logic                     frame_active;
   logic                     frame_start;
   logic                     frame_done;
   logic                     overrun;

   modport master (
      output save_data, err_cnt, chan_en, msb_first,
      input  DATA_OUT, frame_active, frame_start, frame_done, overrun
   );

   modport slave (
      input  save_data, err_cnt, chan_en, msb_first,
      output DATA_OUT, frame_active, frame_start, frame_done, overrun
   );
endinterface

// File: rtl/dff_err_serializer_crc8.sv
// Bit-serial CRC-8 (poly 0x07, init 0x00, no reflection, no final XOR).
//   data_clk : clock
//   reset_n  : async active-low reset
//   i_clr    : synchronous clear to 0x00 (wins over i_en)
//   i_en     : shift i_bit into the CRC this cycle
//   i_bit    : data bit
//   o_crc    : current CRC value
module crc8_serial
   import dff_err_pkg::*;
(
   input  logic       data_clk,
   input  logic       reset_n,
   input  logic       i_clr,
   input  logic       i_en,
   input  logic       i_bit,
   output logic [7:0] o_crc
);

   logic [7:0] r_crc;
   logic       w_fb;

   assign w_fb = r_crc[7] ^ i_bit;

   always_ff @(posedge data_clk or negedge reset_n) begin
      if (!reset_n) begin
         r_crc <= 8'h00;
      end else if (i_clr) begin
         r_crc <= 8'h00;
      end else if (i_en) begin
         r_crc <= {r_crc[6:0], 1'b0} ^ (w_fb ? CRC8_POLY : 8'h00);
      end
   end

   assign o_crc = r_crc;

endmodule

// File: rtl/dff_err_serializer.sv
// DFF error-count serializer: snapshots NUM_CHIPS*CHAINS_PER_CHIP counters
// and shifts them out one bit per data_clk as sync header + payload
// (+ CRC-8 trailer when DFF_ERR_CRC_TRAILER_EN is defined).
//   data_clk : serial bit clock, all logic on its rising edge
//   reset_n  : async active-low reset
//   bus      : dff_err_serializer_if.slave (request, counters, serial out, strobes)
//
// state | meaning
// IDLE  | no frame; capture on request edge or queued request
// HDR   | sending SYNC_WORD, MSB first
// DATA  | sending channels 0..NUM_CH-1, CNT_W bits each
// CRC   | sending CRC-8 trailer, MSB first (DFF_ERR_CRC_TRAILER_EN only)
module dff_err_serializer
   import dff_err_pkg::*;
#(
   parameter int               NUM_CHIPS       = 2,
   parameter int               CHAINS_PER_CHIP = 10,
   parameter int               CNT_W           = 16,
   parameter int               HDR_W           = 8,
   parameter logic [HDR_W-1:0] SYNC_WORD       = HDR_W'(DEF_SYNC_WORD)
)(
   input  logic          data_clk,
   input  logic          reset_n,
   dff_err_serializer_if.slave bus
);

   localparam int NUM_CH = NUM_CHIPS * CHAINS_PER_CHIP;
   localparam int BW     = (CNT_W  > 1) ? $clog2(CNT_W)  : 1;
   localparam int CW     = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
   localparam int HW     = (HDR_W  > 1) ? $clog2(HDR_W)  : 1;

   localparam logic [BW-1:0] BIT_LAST = BW'(CNT_W - 1);
   localparam logic [CW-1:0] CH_LAST  = CW'(NUM_CH - 1);
   localparam logic [HW-1:0] HDR_LAST = HW'(HDR_W - 1);

   state_t           r_state;
   state_t           w_state_nxt;
   logic             r_save_q;
   logic             r_pending;
   logic             r_overrun;
   logic             r_done;
   logic             r_msb;
   logic [HW-1:0]    r_hdr;
   logic [BW-1:0]    r_bit;
   logic [CW-1:0]    r_ch;
   logic [CNT_W-1:0] r_snap [NUM_CH];

   logic             w_req;
   logic             w_capture;
   logic             w_last_bit;
   logic [CNT_W-1:0] w_word;
   logic [BW-1:0]    w_bsel;
   logic [HW-1:0]    w_hsel;
   logic             w_payload_bit;

`ifdef DFF_ERR_CRC_TRAILER_EN
   logic [7:0]       w_crc;
   logic [2:0]       r_crc_idx;
`endif

   assign w_req         = bus.save_data & ~r_save_q;
   assign w_capture     = (r_state == IDLE) & (w_req | r_pending);
   assign w_last_bit    = (r_bit == BIT_LAST) & (r_ch == CH_LAST);
   assign w_word        = r_snap[r_ch];
   assign w_bsel        = r_msb ? (BIT_LAST - r_bit) : r_bit;
   assign w_hsel        = HDR_LAST - r_hdr;
   assign w_payload_bit = w_word[w_bsel];

   // state register
   always_ff @(posedge data_clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // next state
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         IDLE: if (w_capture) w_state_nxt = HDR;
         HDR:  if (r_hdr == HDR_LAST) w_state_nxt = DATA;
`ifdef DFF_ERR_CRC_TRAILER_EN
         DATA: if (w_last_bit) w_state_nxt = CRC;
         CRC:  if (r_crc_idx == 3'd7) w_state_nxt = IDLE;
`else
         DATA: if (w_last_bit) w_state_nxt = IDLE;
`endif
         default: w_state_nxt = IDLE;
      endcase
   end

   // outputs
   always_comb begin
      bus.DATA_OUT     = 1'b0;
      bus.frame_active = 1'b0;
      bus.frame_start  = 1'b0;
      case (r_state)
         HDR: begin
            bus.DATA_OUT     = SYNC_WORD[w_hsel];
            bus.frame_active = 1'b1;
            bus.frame_start  = (r_hdr == '0);
         end
         DATA: begin
            bus.DATA_OUT     = w_payload_bit;
            bus.frame_active = 1'b1;
         end
`ifdef DFF_ERR_CRC_TRAILER_EN
         CRC: begin
            bus.DATA_OUT     = w_crc[3'd7 - r_crc_idx];
            bus.frame_active = 1'b1;
         end
`endif
         default: ;
      endcase
   end

   assign bus.frame_done = r_done;
   assign bus.overrun    = r_overrun;

   // counters, request queue, strobes
   always_ff @(posedge data_clk or negedge reset_n) begin
      if (!reset_n) begin
         r_save_q  <= 1'b0;
         r_pending <= 1'b0;
         r_overrun <= 1'b0;
         r_done    <= 1'b0;
         r_hdr     <= '0;
         r_bit     <= '0;
         r_ch      <= '0;
      end else begin
         r_save_q <= bus.save_data;
         r_done   <= (r_state != IDLE) & (w_state_nxt == IDLE);

         // A request arriving in the very cycle a queued one is consumed
         // takes the slot that was just freed.
         if (w_capture) begin
            r_pending <= w_req & r_pending;
         end else if (w_req && (r_state != IDLE)) begin
            if (!r_pending) r_pending <= 1'b1;
            else            r_overrun <= 1'b1;
         end

         case (r_state)
            HDR: r_hdr <= (r_hdr == HDR_LAST) ? '0 : r_hdr + HW'(1);
            DATA: begin
               if (r_bit == BIT_LAST) begin
                  r_bit <= '0;
                  r_ch  <= (r_ch == CH_LAST) ? '0 : r_ch + CW'(1);
               end else begin
                  r_bit <= r_bit + BW'(1);
               end
            end
            default: ;
         endcase
      end
   end

   // snapshot, intentionally without reset
   always_ff @(posedge data_clk) begin
      if (w_capture) begin
         r_msb <= bus.msb_first;
         for (int k = 0; k < NUM_CH; k++) begin
            r_snap[k] <= bus.chan_en[k] ? bus.err_cnt[k*CNT_W +: CNT_W] : '0;
         end
      end
   end

`ifdef DFF_ERR_CRC_TRAILER_EN
   always_ff @(posedge data_clk or negedge reset_n) begin
      if (!reset_n) begin
         r_crc_idx <= 3'd0;
      end else if (r_state == CRC) begin
         r_crc_idx <= r_crc_idx + 3'd1;
      end else begin
         r_crc_idx <= 3'd0;
      end
   end

   crc8_serial u_crc (
      .data_clk (data_clk),
      .reset_n  (reset_n),
      .i_clr    (w_capture),
      .i_en     (r_state == DATA),
      .i_bit    (w_payload_bit),
      .o_crc    (w_crc)
   );
`endif

endmodule

// File: tb/tb_dff_err_serializer.sv
// Self-checking bench for dff_err_serializer: expected frames are built
// from the input values with plain loops and compared word by word.
module tb_dff_err_serializer;
   import dff_err_pkg::*;

   localparam int NUM_CHIPS       = 2;
   localparam int CHAINS_PER_CHIP = 10;
   localparam int CNT_W           = 16;
   localparam int HDR_W           = 8;
   localparam int NUM_CH          = NUM_CHIPS * CHAINS_PER_CHIP;
   localparam logic [7:0] SYNC    = 8'hA5;
`ifdef DFF_ERR_CRC_TRAILER_EN
   localparam bit CRC_EN = 1'b1;
`else
   localparam bit CRC_EN = 1'b0;
`endif
   localparam int FLEN = frame_len(HDR_W, NUM_CH, CNT_W, CRC_EN);

   logic data_clk = 1'b0;
   logic reset_n  = 1'b0;
   always #5 data_clk = ~data_clk;

   dff_err_serializer_if #(.NUM_CH(NUM_CH), .CNT_W(CNT_W)) bus ();

   dff_err_serializer #(
      .NUM_CHIPS       (NUM_CHIPS),
      .CHAINS_PER_CHIP (CHAINS_PER_CHIP),
      .CNT_W           (CNT_W),
      .HDR_W           (HDR_W),
      .SYNC_WORD       (SYNC)
   ) dut (
      .data_clk (data_clk),
      .reset_n  (reset_n),
      .bus      (bus)
   );

   int total     = 0;
   int bad       = 0;
   int edge_cnt  = 0;
   int last_done = 0;
   int re;
   logic [63:0] last_crc;
   bit exp_q[$];
   logic [CNT_W-1:0]  cnt_v [NUM_CH];
   logic [NUM_CH-1:0] en_v;
   logic              msb_v;

   always @(posedge data_clk) edge_cnt <= edge_cnt + 1;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge data_clk);
      #1;
   endtask

   task automatic apply_inputs();
      bus.chan_en   = en_v;
      bus.msb_first = msb_v;
      for (int k = 0; k < NUM_CH; k++) bus.err_cnt[k*CNT_W +: CNT_W] = cnt_v[k];
   endtask

   task automatic rand_inputs();
      for (int k = 0; k < NUM_CH; k++) cnt_v[k] = CNT_W'($urandom);
      en_v  = NUM_CH'($urandom);
      msb_v = 1'($urandom_range(0, 1));
      apply_inputs();
   endtask

   // Expected frame from the current inputs: header, masked channels in
   // the chosen bit order, then the CRC-8 of the payload bits.
   task automatic build_exp();
      logic [7:0]       crc;
      logic [CNT_W-1:0] w;
      bit               b;
      exp_q.delete();
      crc = 8'h00;
      for (int i = HDR_W - 1; i >= 0; i--) exp_q.push_back(SYNC[i]);
      for (int k = 0; k < NUM_CH; k++) begin
         w = en_v[k] ? cnt_v[k] : '0;
         for (int j = 0; j < CNT_W; j++) begin
            b = msb_v ? w[CNT_W-1-j] : w[j];
            exp_q.push_back(b);
            crc = {crc[6:0], 1'b0} ^ ((crc[7] ^ b) ? 8'h07 : 8'h00);
         end
      end
      if (CRC_EN) for (int i = 7; i >= 0; i--) exp_q.push_back(crc[i]);
   endtask

   task automatic pulse_req(output int at_edge);
      bus.save_data = 1'b1;
      tick();
      at_edge = edge_cnt;
      bus.save_data = 1'b0;
   endtask

   task automatic wait_start(input int max_cyc, output int at_edge);
      at_edge = -1;
      for (int i = 0; i < max_cyc; i++) begin
         if (bus.frame_start === 1'b1) begin
            at_edge = edge_cnt;
            break;
         end
         tick();
      end
   endtask

   task automatic run_frame(input string tag, input int exp_start,
                            input int inj_a, input int inj_b, input int rnd_at);
      int st, act_bad, strb_bad, pos;
      bit got_q[$];
      logic [63:0] gw, ew;
      build_exp();
      wait_start(FLEN + 50, st);
      chk({tag, ".start_edge"}, 64'(st), 64'(exp_start));
      if (st < 0) return;
      act_bad  = 0;
      strb_bad = 0;
      for (int i = 0; i < FLEN; i++) begin
         got_q.push_back(bus.DATA_OUT);
         if (bus.frame_active !== 1'b1) act_bad++;
         if (bus.frame_done !== 1'b0 || bus.frame_start !== (i == 0)) strb_bad++;
         bus.save_data = (i == inj_a || i == inj_b);
         if (i == rnd_at) rand_inputs();
         tick();
      end
      bus.save_data = 1'b0;
      chk({tag, ".active_cycles_bad"}, 64'(act_bad), 64'd0);
      chk({tag, ".strobe_cycles_bad"}, 64'(strb_bad), 64'd0);
      chk({tag, ".frame_done"}, 64'(bus.frame_done), 64'd1);
      chk({tag, ".done_dout"}, 64'(bus.DATA_OUT), 64'd0);
      chk({tag, ".done_active"}, 64'(bus.frame_active), 64'd0);
      last_done = edge_cnt;
      pos = 0;
      gw = '0; ew = '0;
      for (int j = 0; j < HDR_W; j++) begin
         gw = {gw[62:0], got_q[pos]}; ew = {ew[62:0], exp_q[pos]}; pos++;
      end
      chk({tag, ".hdr"}, gw, ew);
      for (int k = 0; k < NUM_CH; k++) begin
         gw = '0; ew = '0;
         for (int j = 0; j < CNT_W; j++) begin
            gw = {gw[62:0], got_q[pos]}; ew = {ew[62:0], exp_q[pos]}; pos++;
         end
         chk($sformatf("%s.ch%0d", tag, k), gw, ew);
      end
`ifdef DFF_ERR_CRC_TRAILER_EN
      gw = '0; ew = '0;
      for (int j = 0; j < 8; j++) begin
         gw = {gw[62:0], got_q[pos]}; ew = {ew[62:0], exp_q[pos]}; pos++;
      end
      chk({tag, ".crc"}, gw, ew);
      last_crc = gw;
`endif
   endtask

   task automatic reset_test();
      int st, noisy, act_seen;
      rand_inputs();
      tick();
      pulse_req(re);
      wait_start(FLEN + 50, st);
      chk("rst.start_edge", 64'(st), 64'(re));
      for (int i = 0; i < 50; i++) begin
         bus.save_data = (i == 20);
         tick();
      end
      bus.save_data = 1'b0;
      reset_n = 1'b0;
      #1;
      chk("rst.dout", 64'(bus.DATA_OUT), 64'd0);
      chk("rst.active", 64'(bus.frame_active), 64'd0);
      chk("rst.start", 64'(bus.frame_start), 64'd0);
      chk("rst.done", 64'(bus.frame_done), 64'd0);
      chk("rst.overrun", 64'(bus.overrun), 64'd0);
      noisy = 0;
      repeat (3) begin
         tick();
         if (bus.frame_done !== 1'b0 || bus.frame_active !== 1'b0) noisy++;
      end
      reset_n = 1'b1;
      for (int i = 0; i < FLEN + 20; i++) begin
         tick();
         if (bus.frame_done !== 1'b0) noisy++;
         if (bus.frame_active !== 1'b0) act_seen++;
      end
      chk("rst.no_done_after_abort", 64'(noisy), 64'd0);
      chk("rst.pending_dropped", 64'(act_seen), 64'd0);
      rand_inputs();
      tick();
      pulse_req(re);
      run_frame("rst_after", re, -1, -1, -1);
      chk("rst_after.overrun", 64'(bus.overrun), 64'd0);
   endtask

   initial begin
      bus.save_data = 1'b0;
      for (int k = 0; k < NUM_CH; k++) cnt_v[k] = CNT_W'(k + 1);
      en_v  = '1;
      msb_v = 1'b0;
      apply_inputs();
      #2;
      chk("reset.dout", 64'(bus.DATA_OUT), 64'd0);
      chk("reset.active", 64'(bus.frame_active), 64'd0);
      chk("reset.start", 64'(bus.frame_start), 64'd0);
      chk("reset.done", 64'(bus.frame_done), 64'd0);
      chk("reset.overrun", 64'(bus.overrun), 64'd0);
      repeat (3) tick();
      reset_n = 1'b1;
      tick();
      tick();

      // counters k+1, LSB first, all enabled
      pulse_req(re);
      run_frame("f1", re, -1, -1, -1);
      tick();

      // MSB first, channel 3 masked
      msb_v    = 1'b1;
      en_v[3]  = 1'b0;
      apply_inputs();
      tick();
      pulse_req(re);
      run_frame("f2", re, -1, -1, -1);

      // one queued request; inputs change mid-frame for the queued frame
      tick();
      rand_inputs();
      tick();
      pulse_req(re);
      run_frame("f3", re, 100, -1, 150);
      chk("f3.overrun", 64'(bus.overrun), 64'd0);
      run_frame("f4", last_done + 1, -1, -1, -1);
      chk("f4.overrun", 64'(bus.overrun), 64'd0);

      // two extra requests: one queued, one lost
      tick();
      rand_inputs();
      tick();
      pulse_req(re);
      run_frame("f5", re, 100, 200, 250);
      chk("f5.overrun", 64'(bus.overrun), 64'd1);
      run_frame("f6", last_done + 1, -1, -1, -1);
      chk("f6.overrun", 64'(bus.overrun), 64'd1);
      tick();
      rand_inputs();
      pulse_req(re);
      run_frame("f7", re, -1, -1, -1);
      chk("f7.overrun", 64'(bus.overrun), 64'd1);

      reset_test();

      for (int n = 0; n < 4; n++) begin
         repeat ($urandom_range(1, 5)) tick();
         rand_inputs();
         pulse_req(re);
         run_frame($sformatf("rnd%0d", n), re, -1, -1, -1);
      end

      for (int k = 0; k < NUM_CH; k++) cnt_v[k] = '0;
      en_v  = '1;
      msb_v = 1'b0;
      apply_inputs();
      tick();
      pulse_req(re);
      run_frame("zero", re, -1, -1, -1);
`ifdef DFF_ERR_CRC_TRAILER_EN
      chk("zero.crc_literal", last_crc, 64'h00);
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/dff_err_serializer.md
Name: dff_err_serializer

Overview:
Parametrised successor to the fixed 2-chip x 10-chain DFF error-count serial output path. Snapshots NUM_CHIPS*CHAINS_PER_CHIP error counters of CNT_W bits and shifts them out one bit per data_clk as a framed stream: sync header, payload, optional CRC. Adds frame strobes, selectable bit order, per-channel masking, queuing of one pending request and overrun detection. Sits between the error counters and the FPGA-to-host serial pin.

Parameters:
NUM_CHIPS, 2, number of chips under test
CHAINS_PER_CHIP, 10, DFF chains per chip
CNT_W, 16, bits per error counter
HDR_W, 8, sync header width (>=1)
SYNC_WORD, 8'hA5, header value, HDR_W bits, always sent MSB first
(derived) NUM_CH = NUM_CHIPS*CHAINS_PER_CHIP; FRAME_LEN = HDR_W + NUM_CH*CNT_W (+8 with CRC)

Ports:
data_clk  in  1  serial bit clock; all logic on its rising edge
reset_n  in  1  asynchronous, active-low reset
save_data  in  1  snapshot request, synchronous to data_clk; rising edge detected internally
err_cnt  in  NUM_CH*CNT_W  flattened counters; channel k = err_cnt[k*CNT_W +: CNT_W], k = chip*CHAINS_PER_CHIP + chain
chan_en  in  NUM_CH  per-channel enable, sampled at snapshot; a disabled channel transmits all zeros
msb_first  in  1  payload bit order, sampled at snapshot (0 = LSB first, matching the legacy stream)
DATA_OUT  out  1  serial data
frame_active  out  1  high on every cycle DATA_OUT carries a frame bit
frame_start  out  1  1-cycle pulse coincident with the first header bit
frame_done  out  1  1-cycle pulse the cycle after the last frame bit
overrun  out  1  sticky flag: a request was lost

Behaviour:
- Reset (async assert, sync release): state IDLE. DATA_OUT, frame_active, frame_start, frame_done, overrun, pending and the edge-detect register all 0. Snapshot registers are not reset.
- Edge detect: req = save_data & ~save_data_q.
- States: IDLE -> HDR -> DATA -> (CRC) -> IDLE.
- IDLE, req or pending at edge N: capture err_cnt masked by chan_en, plus msb_first, into the snapshot. Clear pending. Go to HDR. The first header bit is on DATA_OUT in cycle N+1, with frame_start=1.
- HDR: HDR_W bits of SYNC_WORD, MSB first.
- DATA: channels 0..NUM_CH-1 in ascending order, CNT_W bits each, bit order per the latched msb_first. No gaps between channels.
- The last frame bit is in cycle N+FRAME_LEN. In cycle N+FRAME_LEN+1: state is IDLE, frame_done=1, DATA_OUT=0, frame_active=0.
- Pending request: a new frame starts at the edge ending the frame_done cycle. Its first header bit is in N+FRAME_LEN+2, giving exactly one idle cycle between frames.
- req while busy (HDR/DATA/CRC, or the IDLE cycle in which a capture occurs): sets pending if pending=0; otherwise sets overrun. overrun clears only on reset.
- req in the frame_done cycle while pending=0: accepted immediately as in IDLE.
- Counters: bit index is $clog2(CNT_W) bits, channel index is $clog2(NUM_CH) bits. Both wrap to 0 on a channel/frame boundary. No arithmetic overflow is possible.
- Outside a frame, DATA_OUT=0 and frame_active=0.
- Reset mid-frame: the frame is aborted immediately, no frame_done is issued, and any pending request is discarded.

Optional Feature:
Macro DFF_ERR_CRC_TRAILER_EN.
- Defined: after DATA, send an 8-bit CRC in state CRC.
  - CRC-8, poly x^8+x^2+x+1 (0x07), init 0x00, no reflection, no final XOR.
  - Computed over payload bits only, in transmitted order, updated serially as each bit is sent.
  - Sent MSB first. FRAME_LEN includes +8.
- Undefined: CRC state and logic are absent; DATA goes straight to IDLE.

Decomposition:
- Package dff_err_pkg:
  - state enum (IDLE, HDR, DATA, CRC)
  - CRC8_POLY = 8'h07
  - default SYNC_WORD
  - FRAME_LEN helper function
- One sub-module, crc8_serial (1-bit-per-clock LFSR with clear and enable), instantiated only under the macro.

Test Plan:
- Defaults, err_cnt channel k = k+1, all enabled, msb_first=0, one req: frame_start one cycle after the req edge. 328 bits: 8'hA5 MSB first, then channel 0 = 16'h0001 LSB first, ..., channel 19 = 16'h0014. frame_done in cycle 329.
- Same stimulus with msb_first=1 and chan_en[3]=0: each channel sent MSB first, and channel 3 slot is all zeros.
- Second req at bit 100 of a frame: pending is set. The next frame_start follows frame_done by exactly 1 cycle, and overrun stays 0.
- Two extra reqs during one frame: overrun=1 and remains set through the following frames until reset_n=0.
- reset_n pulsed low at bit 50: all outputs 0 asynchronously, with no frame_done. After release, a new req yields a complete, correct frame.
- With DFF_ERR_CRC_TRAILER_EN and all counters 0: trailer is 8'h00 and frame is 336 bits. With counter patterns, the trailer matches the bench's bit-serial CRC-8 (poly 0x07, init 0x00) model.
